// File: rtl/branch_ctrl_seq_if.sv
// branch_ctrl_seq_if: control bus between main FSM / datapath and the branch sequencer
//   master: drives start, opcode, cond_in; observes all sequencer outputs
//   slave : the sequencer itself
interface branch_ctrl_seq_if;
  logic       start;
  logic [5:0] opcode;
  logic       cond_in;
  logic [1:0] BranchCtrl;
  logic       PCWriteCond;
  logic [1:0] PCSource;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic       ALUOutWrite;
  logic       busy;
  logic       done;
  logic       taken;
  logic       illegal;
  modport master (
    output start, opcode, cond_in,
    input  BranchCtrl, PCWriteCond, PCSource, ALUSrcA, ALUSrcB, ALUOp,
           ALUOutWrite, busy, done, taken, illegal
  );
  modport slave (
    input  start, opcode, cond_in,
    output BranchCtrl, PCWriteCond, PCSource, ALUSrcA, ALUSrcB, ALUOp,
           ALUOutWrite, busy, done, taken, illegal
  );
endinterface

// File: rtl/branch_ctrl_seq.sv
// branch_ctrl_seq: multi-cycle conditional-branch sequencer (IDLE -> TARGET -> COMPARE -> DONE)
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : slave side of branch_ctrl_seq_if (start/opcode/cond_in in, datapath controls out)
module branch_ctrl_seq #(
  parameter logic [5:0] OPC_BEQ = 6'h04,
  parameter logic [5:0] OPC_BNE = 6'h05,
  parameter logic [5:0] OPC_BLE = 6'h06,
  parameter logic [5:0] OPC_BGT = 6'h07
) (
  input logic clk,
  input logic reset,
  branch_ctrl_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, TARGET, COMPARE, DONE} state_t;
  state_t state;
  logic mapped;
  logic [1:0] sel;
  always_comb begin
    mapped = bus.opcode == OPC_BEQ || bus.opcode == OPC_BNE ||
             bus.opcode == OPC_BLE || bus.opcode == OPC_BGT;
    sel = bus.opcode == OPC_BEQ ? 2'b10 :
          bus.opcode == OPC_BNE ? 2'b00 :
          bus.opcode == OPC_BLE ? 2'b01 : 2'b11;
  end
  // Outputs are registered for the state being entered, so every control
  // is clean for the full cycle it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      bus.BranchCtrl  <= 2'b00;
      bus.taken       <= 1'b0;
      bus.PCWriteCond <= 1'b0;
      bus.PCSource    <= 2'b00;
      bus.ALUSrcA     <= 1'b0;
      bus.ALUSrcB     <= 2'b00;
      bus.ALUOp       <= 3'b000;
      bus.ALUOutWrite <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.illegal     <= 1'b0;
    end else begin
      bus.PCWriteCond <= 1'b0;
      bus.PCSource    <= 2'b00;
      bus.ALUSrcA     <= 1'b0;
      bus.ALUSrcB     <= 2'b00;
      bus.ALUOp       <= 3'b000;
      bus.ALUOutWrite <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.illegal     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && mapped) begin
            state           <= TARGET;
            bus.BranchCtrl  <= sel;
            bus.taken       <= 1'b0;
            bus.ALUSrcB     <= 2'b11;
            bus.ALUOp       <= 3'b001;
            bus.ALUOutWrite <= 1'b1;
            bus.busy        <= 1'b1;
          end else if (bus.start) begin
            bus.illegal <= 1'b1;
          end
        end
        TARGET: begin
          state           <= COMPARE;
          bus.ALUSrcA     <= 1'b1;
          bus.ALUOp       <= 3'b010;
          bus.PCSource    <= 2'b01;
          bus.PCWriteCond <= 1'b1;
          bus.busy        <= 1'b1;
        end
        COMPARE: begin
          state     <= DONE;
          bus.taken <= bus.cond_in;
          bus.done  <= 1'b1;
          bus.busy  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_ctrl_seq.sv
// tb_branch_ctrl_seq: scenario tasks plus randomized run against a phase-based reference model
module tb_branch_ctrl_seq;
  logic clk = 0;
  logic reset = 0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  branch_ctrl_seq_if bif();
  branch_ctrl_seq dut (.clk(clk), .reset(reset), .bus(bif.slave));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    bif.start = 0; bif.opcode = 0; bif.cond_in = 0;
    reset = 1;
    #12;
    checks++;
    if ({bif.BranchCtrl, bif.PCWriteCond, bif.PCSource, bif.ALUSrcA, bif.ALUSrcB, bif.ALUOp,
         bif.ALUOutWrite, bif.busy, bif.done, bif.taken, bif.illegal} !== 17'd0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b bc=%b taken=%b, want all 0",
               bif.busy, bif.done, bif.BranchCtrl, bif.taken);
    end
    reset = 0;
    step();
  endtask

  task automatic test_beq();
    int pcwCyc, doneCyc, startCyc;
    bif.start = 1; bif.opcode = 6'h04;
    startCyc = cyc;
    step();
    bif.start = 0;
    checks++;
    if (bif.BranchCtrl !== 2'b10 || bif.PCWriteCond !== 1'b0 || bif.busy !== 1'b1) begin
      failures++;
      $display("FAIL beq_target: got bc=%b pcw=%b busy=%b, want 10 0 1", bif.BranchCtrl, bif.PCWriteCond, bif.busy);
    end
    step();
    bif.cond_in = 1;
    pcwCyc = bif.PCWriteCond ? cyc : -1;
    checks++;
    if (pcwCyc - startCyc !== 2 || bif.BranchCtrl !== 2'b10) begin
      failures++;
      $display("FAIL beq_pcwrite: got offset=%0d bc=%b, want 2 10", pcwCyc - startCyc, bif.BranchCtrl);
    end
    step();
    bif.cond_in = 0;
    doneCyc = bif.done ? cyc : -1;
    checks++;
    if (doneCyc - startCyc !== 3 || bif.taken !== 1'b1 || bif.PCWriteCond !== 1'b0) begin
      failures++;
      $display("FAIL beq_done: got offset=%0d taken=%b pcw=%b, want 3 1 0", doneCyc - startCyc, bif.taken, bif.PCWriteCond);
    end
    step();
    checks++;
    if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.taken !== 1'b1 || bif.BranchCtrl !== 2'b10) begin
      failures++;
      $display("FAIL beq_idle: got busy=%b done=%b taken=%b bc=%b, want 0 0 1 10",
               bif.busy, bif.done, bif.taken, bif.BranchCtrl);
    end
  endtask

  task automatic test_sweep();
    logic [5:0] ops [3] = '{6'h05, 6'h06, 6'h07};
    logic [1:0] sels [3] = '{2'b00, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) begin
      bif.start = 1; bif.opcode = ops[i]; bif.cond_in = 0;
      step();
      bif.start = 0;
      checks++;
      if (bif.BranchCtrl !== sels[i] || bif.ALUSrcB !== 2'b11 || bif.ALUOp !== 3'b001 ||
          bif.ALUSrcA !== 1'b0 || bif.ALUOutWrite !== 1'b1) begin
        failures++;
        $display("FAIL sweep_target op=%h: got bc=%b srcB=%b op=%b srcA=%b aow=%b, want %b 11 001 0 1",
                 ops[i], bif.BranchCtrl, bif.ALUSrcB, bif.ALUOp, bif.ALUSrcA, bif.ALUOutWrite, sels[i]);
      end
      step();
      checks++;
      if (bif.ALUOp !== 3'b010 || bif.PCSource !== 2'b01 || bif.ALUSrcA !== 1'b1 ||
          bif.ALUSrcB !== 2'b00 || bif.PCWriteCond !== 1'b1 || bif.BranchCtrl !== sels[i]) begin
        failures++;
        $display("FAIL sweep_compare op=%h: got op=%b pcs=%b srcA=%b srcB=%b pcw=%b bc=%b",
                 ops[i], bif.ALUOp, bif.PCSource, bif.ALUSrcA, bif.ALUSrcB, bif.PCWriteCond, bif.BranchCtrl);
      end
      step();
      checks++;
      if (bif.done !== 1'b1 || bif.taken !== 1'b0 || bif.ALUOp !== 3'b000) begin
        failures++;
        $display("FAIL sweep_done op=%h: got done=%b taken=%b aluop=%b, want 1 0 000", ops[i], bif.done, bif.taken, bif.ALUOp);
      end
      step();
    end
  endtask

  task automatic test_illegal();
    bif.start = 1; bif.opcode = 6'h23;
    step();
    bif.start = 0;
    checks++;
    if (bif.illegal !== 1'b1 || bif.busy !== 1'b0 || bif.BranchCtrl !== 2'b11) begin
      failures++;
      $display("FAIL illegal_pulse: got illegal=%b busy=%b bc=%b, want 1 0 11", bif.illegal, bif.busy, bif.BranchCtrl);
    end
    step();
    checks++;
    if (bif.illegal !== 1'b0 || bif.busy !== 1'b0 || bif.BranchCtrl !== 2'b11) begin
      failures++;
      $display("FAIL illegal_after: got illegal=%b busy=%b bc=%b, want 0 0 11", bif.illegal, bif.busy, bif.BranchCtrl);
    end
  endtask

  task automatic test_ignore_busy();
    int dones = 0;
    bif.start = 1; bif.opcode = 6'h04;
    step();
    bif.opcode = 6'h05;
    step();
    dones += int'(bif.done);
    bif.opcode = 6'h06; bif.cond_in = 1;
    checks++;
    if (bif.BranchCtrl !== 2'b10 || bif.PCWriteCond !== 1'b1) begin
      failures++;
      $display("FAIL busy_ignore_compare: got bc=%b pcw=%b, want 10 1", bif.BranchCtrl, bif.PCWriteCond);
    end
    bif.start = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      dones += int'(bif.done);
    end
    bif.cond_in = 0;
    checks++;
    if (dones !== 1 || bif.BranchCtrl !== 2'b10 || bif.busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_ignore_done: got dones=%0d bc=%b busy=%b, want 1 10 0", dones, bif.BranchCtrl, bif.busy);
    end
  endtask

  task automatic test_async_reset();
    int dones = 0;
    bif.start = 1; bif.opcode = 6'h07;
    step();
    bif.start = 0;
    step();
    bif.cond_in = 1;
    #2 reset = 1;
    #1;
    checks++;
    if ({bif.BranchCtrl, bif.PCWriteCond, bif.PCSource, bif.ALUSrcA, bif.ALUSrcB, bif.ALUOp,
         bif.ALUOutWrite, bif.busy, bif.done, bif.taken, bif.illegal} !== 17'd0) begin
      failures++;
      $display("FAIL async_reset_outputs: got pcw=%b busy=%b bc=%b aluop=%b, want all 0",
               bif.PCWriteCond, bif.busy, bif.BranchCtrl, bif.ALUOp);
    end
    #1 reset = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      dones += int'(bif.done);
    end
    checks++;
    if (dones !== 0 || bif.busy !== 1'b0 || bif.taken !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_nodone: got dones=%0d busy=%b taken=%b, want 0 0 0", dones, bif.busy, bif.taken);
    end
    bif.start = 1; bif.opcode = 6'h06;
    step();
    bif.start = 0;
    step();
    step();
    checks++;
    if (bif.done !== 1'b1 || bif.taken !== 1'b1 || bif.BranchCtrl !== 2'b01) begin
      failures++;
      $display("FAIL async_reset_recover: got done=%b taken=%b bc=%b, want 1 1 01", bif.done, bif.taken, bif.BranchCtrl);
    end
    bif.cond_in = 0;
    step();
  endtask

  task automatic test_back_to_back();
    int p0 = -1, p1 = -1;
    bif.start = 1; bif.opcode = 6'h05;
    step();
    bif.start = 0;
    step();
    if (bif.PCWriteCond) p0 = cyc;
    step();
    step();
    bif.start = 1; bif.opcode = 6'h07;
    step();
    bif.start = 0;
    step();
    if (bif.PCWriteCond) p1 = cyc;
    checks++;
    if (p0 < 0 || p1 - p0 !== 4 || bif.BranchCtrl !== 2'b11) begin
      failures++;
      $display("FAIL back_to_back: got p0=%0d gap=%0d bc=%b, want gap 4 bc 11", p0, p1 - p0, bif.BranchCtrl);
    end
    step();
    step();
  endtask

  // Reference: a branch occupies the three cycles after acceptance as
  // target / compare / done phases; nothing else is visible on the bus.
  task automatic test_random();
    logic [1:0] bcMap [4] = '{2'b10, 2'b00, 2'b01, 2'b11};
    int phase = 0;
    logic [1:0] expBc = bif.BranchCtrl;
    logic expTaken = bif.taken;
    logic expIllegal;
    logic expBusy, expPcw, expSrcA, expAow, expDone;
    logic [1:0] expPcs, expSrcB;
    logic [2:0] expOp;
    int nextPhase;
    for (int n = 0; n < 400; n++) begin
      bif.start = ($urandom % 3) == 0;
      bif.opcode = ($urandom % 4 == 0) ? 6'($urandom) : 6'(4 + $urandom % 4);
      bif.cond_in = 1'($urandom);
      expIllegal = 0;
      nextPhase = phase == 0 ? 0 : (phase + 1) % 4;
      if (phase == 0 && bif.start && bif.opcode >= 6'h04 && bif.opcode <= 6'h07) begin
        nextPhase = 1;
        expBc = bcMap[bif.opcode - 6'h04];
        expTaken = 0;
      end else if (phase == 0 && bif.start) expIllegal = 1;
      if (phase == 2) expTaken = bif.cond_in;
      phase = nextPhase;
      expBusy = phase != 0;
      expSrcB = phase == 1 ? 2'b11 : 2'b00;
      expOp = phase == 1 ? 3'b001 : phase == 2 ? 3'b010 : 3'b000;
      expAow = phase == 1;
      expSrcA = phase == 2;
      expPcs = phase == 2 ? 2'b01 : 2'b00;
      expPcw = phase == 2;
      expDone = phase == 3;
      step();
      checks++;
      if (bif.BranchCtrl !== expBc || bif.taken !== expTaken || bif.illegal !== expIllegal ||
          bif.busy !== expBusy || bif.ALUSrcB !== expSrcB || bif.ALUOp !== expOp ||
          bif.ALUOutWrite !== expAow || bif.ALUSrcA !== expSrcA || bif.PCSource !== expPcs ||
          bif.PCWriteCond !== expPcw || bif.done !== expDone || (bif.done && bif.illegal)) begin
        failures++;
        $display("FAIL random n=%0d: got bc=%b tk=%b il=%b bz=%b sb=%b op=%b aw=%b sa=%b ps=%b pw=%b dn=%b, want %b %b %b %b %b %b %b %b %b %b %b",
                 n, bif.BranchCtrl, bif.taken, bif.illegal, bif.busy, bif.ALUSrcB, bif.ALUOp, bif.ALUOutWrite,
                 bif.ALUSrcA, bif.PCSource, bif.PCWriteCond, bif.done,
                 expBc, expTaken, expIllegal, expBusy, expSrcB, expOp, expAow, expSrcA, expPcs, expPcw, expDone);
      end
    end
    bif.start = 0;
  endtask

  initial begin
    test_reset();
    test_beq();
    test_sweep();
    test_illegal();
    test_ignore_busy();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
